// File: rtl/cv32e40x_pkg.sv
// Shared cv32e40x types: OBI memory responder response payload and lane count.
package cv32e40x_pkg;

    localparam int unsigned OBI_MEM_BE_W = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } obi_mem_resp_t;

endpackage

// File: rtl/cv32e40x_obi_resp_pipe.sv
// Generic delay line of LATENCY registers; synchronous reset flushes every stage.
module cv32e40x_obi_resp_pipe
    import cv32e40x_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter type         T       = obi_mem_resp_t
) (
    input  logic clk,
    input  logic rst,
    input  T     in_i,
    output T     out_o
);

    T stage_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/cv32e40x_obi_mem_responder.sv
// OBI responder backed by a word-addressed memory; in-order responses after a
// fixed latency, with grant throttled by an outstanding-transaction counter.
module cv32e40x_obi_mem_responder
    import cv32e40x_pkg::*;
#(
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             addr_i,
    input  logic                    we_i,
    input  logic [OBI_MEM_BE_W-1:0] be_i,
    input  logic [31:0]             wdata_i,
    output logic                    rvalid_o,
    output logic [31:0]             rdata_o,
    output logic                    err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      mem [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             accept;
    obi_mem_resp_t    resp_in;
    obi_mem_resp_t    resp_out;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];
    assign idx              = addr_i[IDX_W+1:2];
    assign addr_err         = 32'(addr_i[31:2]) >= DEPTH;

    assign gnt_o  = !rst && !stall_i && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign accept = req_i && gnt_o;

    // Response payload captured at the accept edge; writes and errors carry zero data.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.err   = accept && addr_err;
        if (accept && !we_i && !addr_err) begin
            resp_in.rdata = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && we_i && !addr_err) begin
            for (int unsigned k = 0; k < OBI_MEM_BE_W; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    cv32e40x_obi_resp_pipe #(
        .LATENCY (READ_LATENCY),
        .T       (obi_mem_resp_t)
    ) u_resp_pipe (
        .clk   (clk),
        .rst   (rst),
        .in_i  (resp_in),
        .out_o (resp_out)
    );

    // Gate with rst so a response already in the last stage is dropped during reset.
    assign rvalid_o = resp_out.valid && !rst;
    assign rdata_o  = rvalid_o ? resp_out.rdata : '0;
    assign err_o    = rvalid_o && resp_out.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CNT_W'(MAX_OUTSTANDING));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rvalid_o && !accept && (cnt_q == '0)));

endmodule

// File: tb/tb_cv32e40x_obi_mem_responder.sv
// Bench for cv32e40x_obi_mem_responder: queue-based response model, directed table,
// reset/error/backpressure sequences and a randomized phase.
module tb_cv32e40x_obi_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst, stall, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        req2, gnt2, rvalid2, err2;
    logic [31:0] rdata2;

    always #5 clk = ~clk;

    cv32e40x_obi_mem_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .req_i(req), .gnt_o(gnt),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
    );

    cv32e40x_obi_mem_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(2), .MAX_OUTSTANDING(1)
    ) dut_bp (
        .clk(clk), .rst(rst), .stall_i(stall), .req_i(req2), .gnt_o(gnt2),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t        q[$];
    logic [31:0] mdl_mem [int unsigned];
    int unsigned edge_n = 0;
    int          errors = 0;
    int          checks = 0;

    logic        act_gnt, act_rv, act_err, act_gnt2, act_rv2;
    logic [31:0] act_rd, act_rd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock: drive inputs, check against the model mid-cycle, then advance the model.
    task automatic cycle(input logic r, input logic s, input logic rq, input logic w,
                         input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic        g, rv;
        exp_t        e;
        int unsigned word;
        logic [31:0] v;
        rst = r; stall = s; req = rq; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        act_gnt = gnt; act_rv = rvalid; act_rd = rdata; act_err = err;
        act_gnt2 = gnt2; act_rv2 = rvalid2; act_rd2 = rdata2;
        g  = !r && !s && (q.size() < MAXO);
        rv = !r && (q.size() > 0) && (q[0].due == edge_n);
        chk("gnt", 32'(act_gnt), 32'(g));
        chk("rvalid", 32'(act_rv), 32'(rv));
        chk("rdata", act_rd, rv ? q[0].rdata : 32'h0);
        chk("err", 32'(act_err), rv ? 32'(q[0].err) : 32'h0);
        if (r) begin
            q.delete();
        end else begin
            if (rv) void'(q.pop_front());
            if (rq && g) begin
                word    = a >> 2;
                e.due   = edge_n + LAT;
                e.rdata = 32'h0;
                e.err   = 1'b0;
                if (word >= DEPTH) begin
                    e.err = 1'b1;
                end else if (w) begin
                    v = mdl_mem.exists(word) ? mdl_mem[word] : 32'h0;
                    for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
                    mdl_mem[word] = v;
                end else begin
                    e.rdata = mdl_mem[word];
                end
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,   4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h20,   4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'h20,   4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h20,   4'h5, 32'h11223344, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h20,   4'h0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h20,   4'h0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 32'hDE22BE44, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h1000, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 32'hC0DE0000, 1'b0};

        rst = 1'b1; stall = 1'b0; req = 1'b0; we = 1'b0; req2 = 1'b0;
        addr = 32'h0; be = 4'h0; wdata = 32'h0;
        @(posedge clk);
        #1;
        edge_n++;

        // Reset held with req high, then first cycle after release must grant.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
            chk("rst_gnt", 32'(act_gnt), 32'h0);
            chk("rst_rvalid", 32'(act_rv), 32'h0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("rel_gnt", 32'(act_gnt), 32'h1);

        // Prefill the word window used by the bench.
        for (int w = 0; w < 16; w++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'(w << 2), 4'hF, 32'hC0DE0000 | 32'(w));
            if (!act_gnt) w--;
        end
        idle(4);

        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b0, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            chk($sformatf("tbl%0d_gnt", i), 32'(act_gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rvalid", i), 32'(act_rv), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata", i), act_rd, tbl[i].rdata);
            chk($sformatf("tbl%0d_err", i), 32'(act_err), 32'(tbl[i].err));
        end
        idle(4);

        // Reset mid-flight: two reads granted, reset next cycle, nothing may come back.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        chk("mid_gnt0", 32'(act_gnt), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        chk("mid_gnt1", 32'(act_gnt), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("mid_rst_rvalid", 32'(act_rv), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("mid_after_rvalid", 32'(act_rv), 32'h0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        idle(1);
        idle(1);
        chk("retained_rvalid", 32'(act_rv), 32'h1);
        chk("retained_rdata", act_rd, 32'hDE22BE44);

        // Single-outstanding instance with req held: grant, two blocked cycles, response.
        req2 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h12345678);
            chk($sformatf("bp%0d_gnt", i), 32'(act_gnt2), (i % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("bp%0d_rvalid", i), 32'(act_rv2), (i % 3 == 2) ? 32'h1 : 32'h0);
            chk($sformatf("bp%0d_rdata", i), act_rd2, 32'h0);
        end
        req2 = 1'b0;
        idle(4);

        // Randomized traffic with stalls, errors and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            if ($urandom_range(7) == 0) a = 32'h1000 | $urandom;
            else a = 32'($urandom_range(15) << 2) | 32'($urandom_range(3));
            cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), a, 4'($urandom), $urandom);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
